byte_unstriping_nlane: RTL and testbench

Parametrised successor to the two-lane byte unstriper. Recombines NUM_LANES striped lanes into one ordered word stream on a single clock. Word k of the original stream always travels on lane k mod NUM_LANES. Per-lane FIFOs absorb inter-lane skew, and a round-robin read pointer restores order behind a valid/ready output handshake. Sits between the per-lane receive paths and the demux stage.

---
 rtl/byte_unstriping_nlane_pkg.sv | 23 ++
 rtl/byte_unstriping_nlane_lane_fifo.sv | 78 +++++++
 rtl/byte_unstriping_nlane.sv | 127 ++++++++++++
 tb/tb_byte_unstriping_nlane.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_unstriping_nlane_pkg.sv
// Shared definitions for the N-lane byte unstriper: default parameter
// values and a width helper that never returns zero.
package unstripe_pkg;

    localparam int LANES_DEF = 2;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // ceil(log2(value)), but at least 1 so the result is always a legal width
    function automatic int clog2_safe(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_unstriping_nlane_lane_fifo.sv
// Single-lane skew-absorbing FIFO. Head word is presented combinationally
// on dout; full/empty are decoded directly from the occupancy count so the
// write-side drop decision never depends on a same-cycle pop.
module lane_fifo
    import unstripe_pkg::*;
#(
    parameter int DATA_WIDTH = WIDTH_DEF,
    parameter int FIFO_DEPTH = DEPTH_DEF
) (
    input  logic                  clk_f,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf_set
);

    localparam int PTR_W = clog2_safe(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign empty   = (count_r == {CNT_W{1'b0}});
    assign full    = (count_r == DEPTH_CNT);
    assign wr_en_s = push && !full && !clr;
    assign rd_en_s = pop && !empty && !clr;
    assign ovf_set = push && full;
    assign dout    = mem_r[rd_ptr_r];

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clk_f) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/byte_unstriping_nlane.sv
// N-lane byte unstriper: word k of the original stream arrives on lane
// k mod NUM_LANES. Per-lane FIFOs absorb skew; a round-robin read pointer
// that only advances on a load restores the original order behind a
// registered valid/ready output.
module byte_unstriping_nlane
    import unstripe_pkg::*;
#(
    parameter int NUM_LANES  = LANES_DEF,
    parameter int DATA_WIDTH = WIDTH_DEF,
    parameter int FIFO_DEPTH = DEPTH_DEF
) (
    input  logic                            clk_f,
    input  logic                            reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_stripe,
    input  logic [NUM_LANES-1:0]            valid_stripe,
    input  logic                            realign,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [NUM_LANES-1:0]            lane_empty,
    output logic [NUM_LANES-1:0]            lane_full,
    output logic [NUM_LANES-1:0]            overflow
);

    localparam int LANE_W = clog2_safe(NUM_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    logic [LANE_W-1:0]     rd_lane_r;
    logic [NUM_LANES-1:0]  pop_s;
    logic [NUM_LANES-1:0]  ovf_set_s;
    logic [NUM_LANES-1:0]  empty_s;
    logic [NUM_LANES-1:0]  full_s;
    logic [DATA_WIDTH-1:0] head_s [NUM_LANES];
    logic [DATA_WIDTH-1:0] head_sel_s;
    logic                  rd_empty_s;
    logic                  load_s;

    assign lane_empty = empty_s;
    assign lane_full  = full_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_f   (clk_f),
            .reset   (reset),
            .clr     (realign),
            .push    (valid_stripe[g]),
            .din     (data_stripe[g*DATA_WIDTH +: DATA_WIDTH]),
            .pop     (pop_s[g]),
            .dout    (head_s[g]),
            .empty   (empty_s[g]),
            .full    (full_s[g]),
            .ovf_set (ovf_set_s[g])
        );
    end

    // Select the head word and empty flag of the lane the read pointer is on
    always_comb begin
        head_sel_s = {DATA_WIDTH{1'b0}};
        rd_empty_s = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_lane_r == LANE_W'(i)) begin
                head_sel_s = head_s[i];
                rd_empty_s = empty_s[i];
            end else begin
                head_sel_s = head_sel_s;
                rd_empty_s = rd_empty_s;
            end
        end
    end

    // Load when the output slot is free or being drained and the current lane has data
    always_comb begin
        load_s = (!valid_out || ready_out) && !rd_empty_s && !realign;
        pop_s  = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            if (load_s && (rd_lane_r == LANE_W'(i))) begin
                pop_s[i] = 1'b1;
            end else begin
                pop_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin read pointer; realign wins over a load
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_out  <= {DATA_WIDTH{1'b0}};
            valid_out <= 1'b0;
            rd_lane_r <= {LANE_W{1'b0}};
        end else if (realign) begin
            data_out  <= data_out;
            valid_out <= 1'b0;
            rd_lane_r <= {LANE_W{1'b0}};
        end else if (load_s) begin
            data_out  <= head_sel_s;
            valid_out <= 1'b1;
            if (rd_lane_r == LAST_LANE) begin
                rd_lane_r <= {LANE_W{1'b0}};
            end else begin
                rd_lane_r <= rd_lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
            end
        end else if (ready_out) begin
            data_out  <= data_out;
            valid_out <= 1'b0;
            rd_lane_r <= rd_lane_r;
        end else begin
            data_out  <= data_out;
            valid_out <= valid_out;
            rd_lane_r <= rd_lane_r;
        end
    end

    // Sticky per-lane overflow flags, cleared only by reset or realign
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            overflow <= {NUM_LANES{1'b0}};
        end else if (realign) begin
            overflow <= {NUM_LANES{1'b0}};
        end else begin
            overflow <= overflow | ovf_set_s;
        end
    end

endmodule

// File: tb/tb_byte_unstriping_nlane.sv
// Bench for byte_unstriping_nlane (4 lanes, 8-bit words, depth 4).
// A queue-based model tracks the expected outputs; a negedge process
// compares every output each cycle, and directed steps pin literal values.
module tb_byte_unstriping_nlane;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int FD = 4;

    logic              clk_f = 1'b0;
    logic              reset = 1'b0;
    logic [NL*DW-1:0]  data_stripe = '0;
    logic [NL-1:0]     valid_stripe = '0;
    logic              realign = 1'b0;
    logic              ready_out = 1'b1;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic [NL-1:0]     lane_empty;
    logic [NL-1:0]     lane_full;
    logic [NL-1:0]     overflow;

    int checks = 0;
    int failures = 0;

    byte_unstriping_nlane #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .data_stripe  (data_stripe),
        .valid_stripe (valid_stripe),
        .realign      (realign),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .lane_empty   (lane_empty),
        .lane_full    (lane_full),
        .overflow     (overflow)
    );

    always #5 clk_f = ~clk_f;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq [NL][$];
    int            m_rd = 0;
    logic          m_vout = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic [NL-1:0] m_ovf = '0;

    task automatic m_step();
        bit            ld;
        logic [DW-1:0] head;
        if (reset) begin
            for (int i = 0; i < NL; i++) mq[i].delete();
            m_rd = 0; m_vout = 1'b0; m_dout = '0; m_ovf = '0;
        end else if (realign) begin
            for (int i = 0; i < NL; i++) mq[i].delete();
            m_rd = 0; m_vout = 1'b0; m_ovf = '0;
        end else begin
            ld = (!m_vout || ready_out) && (mq[m_rd].size() != 0);
            head = ld ? mq[m_rd][0] : '0;
            for (int i = 0; i < NL; i++) begin
                if (valid_stripe[i]) begin
                    if (mq[i].size() == FD) m_ovf[i] = 1'b1;
                    else mq[i].push_back(data_stripe[i*DW +: DW]);
                end
            end
            if (ld) begin
                void'(mq[m_rd].pop_front());
                m_dout = head; m_vout = 1'b1; m_rd = (m_rd + 1) % NL;
            end else if (ready_out) begin
                m_vout = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_f or posedge reset);
        m_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial forever begin
        logic [NL-1:0] e_empty, e_full;
        @(negedge clk_f);
        for (int i = 0; i < NL; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == FD);
        end
        chk("cmp_valid_out", {31'd0, valid_out}, {31'd0, m_vout});
        chk("cmp_data_out", {24'd0, data_out}, {24'd0, m_dout});
        chk("cmp_lane_empty", {28'd0, lane_empty}, {28'd0, e_empty});
        chk("cmp_lane_full", {28'd0, lane_full}, {28'd0, e_full});
        chk("cmp_overflow", {28'd0, overflow}, {28'd0, m_ovf});
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_f);
        #1;
    endtask

    task automatic drive(input logic [NL-1:0] vs, input logic [31:0] d);
        valid_stripe = vs;
        data_stripe  = d;
    endtask

    logic [DW-1:0] exp4 [16] = '{8'h31, 8'h32, 8'h33, 8'h21, 8'h35, 8'h36, 8'h37, 8'h22,
                                 8'h39, 8'h3A, 8'h3B, 8'h23, 8'h3D, 8'h3E, 8'h3F, 8'h24};
    logic [DW-1:0] got [$];
    logic [31:0]   wdat;

    initial begin
        #1 reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_data", {24'd0, data_out}, 32'd0);
        chk("reset_empty", {28'd0, lane_empty}, 32'hF);
        chk("reset_ovf", {28'd0, overflow}, 32'd0);

        // 1: aligned stream, 2-edge latency, one word per cycle
        drive(4'hF, 32'h03020100); cyc();
        drive(4'hF, 32'h07060504); cyc();
        drive(4'h0, 32'h0);
        chk("t1_first_valid", {31'd0, valid_out}, 32'd1);
        chk("t1_first_data", {24'd0, data_out}, 32'h00);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk("t1_seq", {24'd0, data_out}, k);
        end
        cyc();
        chk("t1_drained", {31'd0, valid_out}, 32'd0);

        // 2: lane 1 lags by three cycles
        drive(4'b1101, 32'hA3A200A0); cyc();
        drive(4'h0, 32'h0); cyc();
        chk("t2_a0", {24'd0, data_out}, 32'hA0);
        cyc();
        chk("t2_stall", {31'd0, valid_out}, 32'd0);
        drive(4'b0010, 32'h0000A100); cyc();
        drive(4'h0, 32'h0);
        chk("t2_stall2", {31'd0, valid_out}, 32'd0);
        cyc(); chk("t2_a1", {24'd0, data_out}, 32'hA1);
        cyc(); chk("t2_a2", {24'd0, data_out}, 32'hA2);
        cyc(); chk("t2_a3", {24'd0, data_out}, 32'hA3);
        cyc(); chk("t2_idle", {31'd0, valid_out}, 32'd0);

        // 3: backpressure holds the output stable
        drive(4'hF, 32'h13121110); cyc();
        drive(4'h0, 32'h0); cyc();
        ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3_hold_data", {24'd0, data_out}, 32'h10);
            chk("t3_hold_valid", {31'd0, valid_out}, 32'd1);
        end
        ready_out = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cyc();
            chk("t3_resume", {24'd0, data_out}, 32'h10 + k);
        end
        cyc(); chk("t3_idle", {31'd0, valid_out}, 32'd0);

        // 4: overflow on lane 0 with output stalled
        ready_out = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, 32'h20 + k); cyc();
        end
        chk("t4_full", {31'd0, lane_full[0]}, 32'd1);
        chk("t4_ovf", {31'd0, overflow[0]}, 32'd1);
        chk("t4_head", {24'd0, data_out}, 32'h20);
        for (int k = 0; k < 4; k++) begin
            wdat = {8'h33 + 8'(4*k), 8'h32 + 8'(4*k), 8'h31 + 8'(4*k), 8'h00};
            drive(4'b1110, wdat); cyc();
        end
        drive(4'h0, 32'h0);
        chk("t4_pending", {24'd0, data_out}, 32'h20);
        ready_out = 1'b1;
        got.delete();
        for (int c = 0; c < 25; c++) begin
            cyc();
            if (valid_out) got.push_back(data_out);
        end
        chk("t4_count", got.size(), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < got.size()) chk("t4_order", {24'd0, got[k]}, {24'd0, exp4[k]});
        end
        chk("t4_ovf_sticky", {31'd0, overflow[0]}, 32'd1);

        // 5: realign with words buffered, then a fresh stream from lane 0
        ready_out = 1'b0;
        drive(4'b1110, 32'h43424100); cyc();
        drive(4'h0, 32'h0);
        realign = 1'b1; cyc();
        realign = 1'b0;
        chk("t5_empty", {28'd0, lane_empty}, 32'hF);
        chk("t5_valid", {31'd0, valid_out}, 32'd0);
        chk("t5_ovf", {28'd0, overflow}, 32'd0);
        chk("t5_data_hold", {24'd0, data_out}, 32'h24);
        ready_out = 1'b1;
        drive(4'hF, 32'h53525150); cyc();
        drive(4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_restart", {24'd0, data_out}, 32'h50 + k);
        end

        // 6: asynchronous reset between edges during traffic
        ready_out = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, 32'h60 + k); cyc();
        end
        drive(4'h0, 32'h0);
        chk("t6_pre_ovf", {31'd0, overflow[0]}, 32'd1);
        chk("t6_pre_valid", {31'd0, valid_out}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, valid_out}, 32'd0);
        chk("t6_async_ovf", {28'd0, overflow}, 32'd0);
        chk("t6_async_empty", {28'd0, lane_empty}, 32'hF);
        chk("t6_async_data", {24'd0, data_out}, 32'd0);
        cyc(); cyc();
        reset = 1'b0;
        ready_out = 1'b1;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
